cdc_bus_qualifier: RTL and testbench

//   Consumes the output of a CDC synchronizer stage. Accepts a new value only after it has been stable
//   for STABLE_CYCLES consecutive samples, which filters out skew and glitches between bits of a

---
 rtl/cdc_bus_qualifier_if.sv | 15 +
 rtl/cdc_bus_qualifier.sv | 85 ++++++++
 tb/tb_cdc_bus_qualifier.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/cdc_bus_qualifier_if.sv
// cdc_bus_qualifier_if: bus bundle between a CDC synchronizer consumer and its qualifier.
interface cdc_bus_qualifier_if #(
    parameter int WIDTH        = 8,
    parameter int GLITCH_CNT_W = 8
);
    logic [WIDTH-1:0]        i;
    logic                    clear_glitch;
    logic [WIDTH-1:0]        o;
    logic                    o_valid;
    logic                    update;
    logic [GLITCH_CNT_W-1:0] glitch_count;
    logic                    busy;
    modport master (output i, clear_glitch, input o, o_valid, update, glitch_count, busy);
    modport slave  (input i, clear_glitch, output o, o_valid, update, glitch_count, busy);
endinterface

// File: rtl/cdc_bus_qualifier.sv
// cdc_bus_qualifier: accepts a synchronized bus value only after STABLE_CYCLES identical samples.
module cdc_bus_qualifier #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 4,
    parameter int GLITCH_CNT_W  = 8
) (
    input logic                clk,
    input logic                rst,
    cdc_bus_qualifier_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    typedef enum logic {IDLE, QUAL} state_t;
    state_t                  state_q, state_d;
    logic [WIDTH-1:0]        cand_q, cand_d, o_q, o_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    valid_q, valid_d, upd_q, upd_d, glitch;
    logic [GLITCH_CNT_W-1:0] gc_q, gc_d;
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        valid_d = valid_q;
        upd_d   = 1'b0;
        glitch  = 1'b0;
        if (state_q == IDLE) begin
            if (!(valid_q && bus.i == o_q)) begin
                if (STABLE_CYCLES == 1) begin
                    o_d     = bus.i;
                    valid_d = 1'b1;
                    upd_d   = 1'b1;
                end else begin
                    cand_d  = bus.i;
                    cnt_d   = CW'(1);
                    state_d = QUAL;
                end
            end
        end else if (bus.i == cand_q) begin
            if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
                o_d     = cand_q;
                valid_d = 1'b1;
                upd_d   = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            glitch = 1'b1;
            // falling back to the already-qualified value abandons the candidate
            if (valid_q && bus.i == o_q) begin
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                cand_d = bus.i;
                cnt_d  = CW'(1);
            end
        end
        gc_d = bus.clear_glitch ? '0 : (glitch && !(&gc_q)) ? gc_q + 1'b1 : gc_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            o_q     <= '0;
            valid_q <= 1'b0;
            upd_q   <= 1'b0;
            gc_q    <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
            valid_q <= valid_d;
            upd_q   <= upd_d;
            gc_q    <= gc_d;
        end
    end
    assign bus.o            = o_q;
    assign bus.o_valid      = valid_q;
    assign bus.update       = upd_q;
    assign bus.glitch_count = gc_q;
    assign bus.busy         = (state_q == QUAL);
endmodule

// File: tb/tb_cdc_bus_qualifier.sv
// tb_cdc_bus_qualifier: directed and random checks of three qualifier configurations against a run-length model.
module tb_cdc_bus_qualifier;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    cdc_bus_qualifier_if #(.WIDTH(8), .GLITCH_CNT_W(8)) bus_a ();
    cdc_bus_qualifier_if #(.WIDTH(8), .GLITCH_CNT_W(2)) bus_b ();
    cdc_bus_qualifier_if #(.WIDTH(8), .GLITCH_CNT_W(8)) bus_c ();
    cdc_bus_qualifier #(.WIDTH(8), .STABLE_CYCLES(4), .GLITCH_CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    cdc_bus_qualifier #(.WIDTH(8), .STABLE_CYCLES(4), .GLITCH_CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    cdc_bus_qualifier #(.WIDTH(8), .STABLE_CYCLES(1), .GLITCH_CNT_W(8)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));
    // model index 0: STABLE_CYCLES=4 (dut_a, dut_b); index 1: STABLE_CYCLES=1 (dut_c)
    logic [7:0] m_rv [2];
    logic [7:0] m_o [2];
    int m_rl [2];
    bit m_v [2];
    bit m_u [2];
    int gc_a, gc_b, gc_c;
    logic [7:0] cur;
    function automatic bit m_busy(input int k);
        return m_rl[k] > 0 && !(m_v[k] && m_rv[k] == m_o[k]);
    endfunction
    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_rv[k] = '0; m_o[k] = '0; m_rl[k] = 0; m_v[k] = 0; m_u[k] = 0;
        end
        gc_a = 0; gc_b = 0; gc_c = 0;
    endtask
    task automatic model_step(input logic [7:0] v, input bit clr);
        for (int k = 0; k < 2; k++) begin
            int s;
            bit g;
            s = (k == 0) ? 4 : 1;
            g = m_busy(k) && v != m_rv[k];
            m_rl[k] = (m_rl[k] > 0 && v == m_rv[k]) ? ((m_rl[k] + 1 > s) ? s : m_rl[k] + 1) : 1;
            m_rv[k] = v;
            m_u[k] = (m_rl[k] == s) && !(m_v[k] && v == m_o[k]);
            if (m_u[k]) begin
                m_o[k] = v;
                m_v[k] = 1;
            end
            if (k == 0) begin
                gc_a = clr ? 0 : (g && gc_a < 255) ? gc_a + 1 : gc_a;
                gc_b = clr ? 0 : (g && gc_b < 3) ? gc_b + 1 : gc_b;
            end else begin
                gc_c = clr ? 0 : (g && gc_c < 255) ? gc_c + 1 : gc_c;
            end
        end
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic check_all();
        chk("a.o", 32'(bus_a.o), 32'(m_o[0]));
        chk("a.o_valid", 32'(bus_a.o_valid), 32'(m_v[0]));
        chk("a.update", 32'(bus_a.update), 32'(m_u[0]));
        chk("a.busy", 32'(bus_a.busy), 32'(m_busy(0)));
        chk("a.glitch_count", 32'(bus_a.glitch_count), 32'(gc_a));
        chk("b.o", 32'(bus_b.o), 32'(m_o[0]));
        chk("b.update", 32'(bus_b.update), 32'(m_u[0]));
        chk("b.glitch_count", 32'(bus_b.glitch_count), 32'(gc_b));
        chk("c.o", 32'(bus_c.o), 32'(m_o[1]));
        chk("c.o_valid", 32'(bus_c.o_valid), 32'(m_v[1]));
        chk("c.update", 32'(bus_c.update), 32'(m_u[1]));
        chk("c.busy", 32'(bus_c.busy), 32'(m_busy(1)));
        chk("c.glitch_count", 32'(bus_c.glitch_count), 32'(gc_c));
    endtask
    task automatic step(input logic [7:0] v, input bit clr);
        bus_a.i = v; bus_b.i = v; bus_c.i = v;
        bus_a.clear_glitch = clr; bus_b.clear_glitch = clr; bus_c.clear_glitch = clr;
        model_step(v, clr);
        @(posedge clk);
        #1;
        check_all();
    endtask
    task automatic check_zero(input string tag);
        chk({tag, ".o"}, 32'(bus_a.o), 32'h0);
        chk({tag, ".o_valid"}, 32'(bus_a.o_valid), 32'h0);
        chk({tag, ".update"}, 32'(bus_a.update), 32'h0);
        chk({tag, ".busy"}, 32'(bus_a.busy), 32'h0);
        chk({tag, ".glitch_count"}, 32'(bus_a.glitch_count), 32'h0);
    endtask
    // async pulse issued mid-cycle, starting from posedge+1
    task automatic async_reset(input string tag);
        #3 rst = 1'b1;
        #1 check_zero(tag);
        model_reset();
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask
    initial begin
        bus_a.i = '0; bus_b.i = '0; bus_c.i = '0;
        bus_a.clear_glitch = 0; bus_b.clear_glitch = 0; bus_c.clear_glitch = 0;
        model_reset();
        @(posedge clk);
        #1 check_zero("reset");
        rst = 1'b0;
        // first qualification of 0x00 after reset
        for (int n = 1; n <= 4; n++) begin
            step(8'h00, 0);
            chk("t1.update_edge", 32'(bus_a.update), (n == 4) ? 32'h1 : 32'h0);
        end
        chk("t1.o_valid", 32'(bus_a.o_valid), 32'h1);
        step(8'h00, 0);
        chk("t1.single_pulse", 32'(bus_a.update), 32'h0);
        // short excursion to 0x5A is discarded
        step(8'h5A, 0);
        step(8'h5A, 0);
        step(8'h00, 0);
        chk("t3.o", 32'(bus_a.o), 32'h00);
        chk("t3.glitch_count", 32'(bus_a.glitch_count), 32'h1);
        chk("t3.busy", 32'(bus_a.busy), 32'h0);
        step(8'h00, 0);
        // step to 0xA5
        for (int n = 1; n <= 4; n++) begin
            step(8'hA5, 0);
            chk("t2.busy", 32'(bus_a.busy), (n < 4) ? 32'h1 : 32'h0);
            chk("t2.update", 32'(bus_a.update), (n == 4) ? 32'h1 : 32'h0);
        end
        chk("t2.o", 32'(bus_a.o), 32'hA5);
        repeat (5) step(8'h00, 0);
        // candidate replaced mid-qualification
        step(8'h11, 0);
        step(8'h11, 0);
        for (int n = 1; n <= 4; n++) begin
            step(8'h22, 0);
            chk("t4.update", 32'(bus_a.update), (n == 4) ? 32'h1 : 32'h0);
        end
        chk("t4.o", 32'(bus_a.o), 32'h22);
        chk("t4.glitch_count", 32'(bus_a.glitch_count), 32'h2);
        step(8'h22, 0);
        // saturation of the 2-bit counter
        repeat (3) begin
            step(8'h33, 0);
            step(8'h22, 0);
        end
        chk("t5.sat", 32'(bus_b.glitch_count), 32'h3);
        chk("t5.wide", 32'(bus_a.glitch_count), 32'h5);
        step(8'h22, 1);
        chk("t5.clear", 32'(bus_b.glitch_count), 32'h0);
        step(8'h33, 0);
        step(8'h22, 1);
        chk("t5.clear_vs_glitch", 32'(bus_b.glitch_count), 32'h0);
        // async reset mid-qualification
        step(8'h44, 0);
        step(8'h44, 0);
        chk("t6.busy_pre", 32'(bus_a.busy), 32'h1);
        async_reset("t6.rst");
        model_step(8'h44, 0);
        check_all();
        for (int n = 2; n <= 4; n++) begin
            step(8'h44, 0);
            chk("t6.update", 32'(bus_a.update), (n == 4) ? 32'h1 : 32'h0);
        end
        chk("t6.o", 32'(bus_a.o), 32'h44);
        // random sticky stimulus
        cur = 8'h44;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) < 4) begin
                case ($urandom_range(0, 3))
                    0: cur = 8'h00;
                    1: cur = 8'hA5;
                    2: cur = 8'h5A;
                    default: cur = 8'($urandom);
                endcase
            end
            if ($urandom_range(0, 149) == 0) begin
                bus_a.i = cur; bus_b.i = cur; bus_c.i = cur;
                async_reset("rnd.rst");
                model_step(cur, bus_a.clear_glitch);
                check_all();
            end else begin
                step(cur, $urandom_range(0, 15) == 0);
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
